muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit, the responder side of the EX-stage request/grant/result-valid offload handshake (same protocol shape as the FPU port).
- EX issues `req_i`; the unit grants, latches operands, computes over multiple cycles and returns one `rvalid_o` pulse with the 32-bit result.
- Sits beside the basic ALU in EX; EX muxes `result_o` into the ALU result path and stalls on `busy_o`.

Parameters:
- ISA_M, 1, enables the unit; when 0: `gnt_o`, `rvalid_o`, `busy_o` tied 0 and `result_o` tied 0, no state logic.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  asynchronous active-low reset
- req_i  in  1  request from EX, qualified by `gnt_o`
- gnt_o  out  1  unit ready to accept; request accepted when `req_i && gnt_o`
- op_i  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand_a_i  in  32  rs1 value
- operand_b_i  in  32  rs2 value
- flush_i  in  1  abort any in-flight operation
- result_o  out  32  result, valid when `rvalid_o`
- rvalid_o  out  1  one-cycle result strobe; no back-pressure, EX always accepts
- busy_o  out  1  operation in flight, result not yet delivered

Behaviour:
- Clock and reset: one clock `clk_i`; reset `rst_n_i` is asynchronous, active-low.
- Reset values: state IDLE, `gnt_o`=1 (when ISA_M), `rvalid_o`=0, `busy_o`=0, `result_o`=0, counter=0, all datapath registers 0.
- States:
  - IDLE: `gnt_o`=1. On accept, latch `op`, operands, sign flags and magnitudes.
    - Normal operations go to CALC with counter=31.
    - Special divide cases go directly to DONE.
  - CALC: one bit per cycle.
    - Multiply: shift-add on 32-bit magnitudes into a 64-bit accumulator.
    - Divide: restoring divide on magnitudes with a 32-bit partial remainder.
    - Counter decrements each cycle; at 0 go to DONE.
  - DONE: apply sign correction and select the output word, drive `rvalid_o`=1 for exactly one cycle, return to IDLE.
- Latency: accept at edge E0; normal operations assert `rvalid_o` in cycle E0+33 (32 CALC cycles plus DONE). Special cases assert `rvalid_o` at E0+1.
- Throughput: `gnt_o`=0 outside IDLE. A new request may be accepted in the cycle after DONE (IDLE); no accept during DONE.
- `busy_o` = (state != IDLE) && !`rvalid_o`.
- Signedness:
  - MUL and MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV and REM: signed.
  - The product is negated when operand signs differ (signed operands only).
  - The quotient is negated when signs differ.
  - The remainder takes the dividend's sign.
- Output select: MUL gives product[31:0]; MULH, MULHSU and MULHU give product[63:32].
- Divide by zero (b==0, detected at accept): quotient=0xFFFF_FFFF, remainder=a. Applies to signed and unsigned forms.
- Signed overflow (DIV/REM with a=0x8000_0000, b=0xFFFF_FFFF): quotient=0x8000_0000, remainder=0.
- Flush:
  - `flush_i` in any state forces IDLE at the next edge; no `rvalid_o` for the aborted operation. A DONE cycle coincident with flush still suppresses `rvalid_o`.
  - `flush_i` together with `req_i` in IDLE: flush wins, nothing accepted.
- Input stability: operand and op inputs are ignored except in the accept cycle.
- `result_o` holds its last value between strobes.
- Reset mid-operation: immediate return to reset values; no result delivered.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
  - Defined: multiply operations use a single-cycle combinational 33x33 signed multiplier. IDLE on accept goes straight to DONE, so `rvalid_o` asserts at E0+1. Divide is unchanged.
  - Undefined: multiply uses the 32-cycle shift-add path, latency E0+33.

Test Plan:
- MUL a=7, b=0xFFFF_FFFD (-3) -> `rvalid_o` at E0+33 (E0+1 with MULDIV_FAST_MUL_EN), result 0xFFFF_FFEB; `busy_o` high E0+1..E0+32.
- MULH a=b=0x8000_0000 -> 0x4000_0000; MULHU same operands -> 0x4000_0000; MULHSU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> 0xFFFF_FFFF.
- DIV a=0xFFFF_FFF9 (-7), b=2 -> 0xFFFF_FFFD; REM same operands -> 0xFFFF_FFFF; DIVU a=100, b=7 -> 14; REMU same operands -> 2.
- DIVU a=0x1234, b=0 -> 0xFFFF_FFFF at E0+1; REM a=0x1234, b=0 -> 0x1234; DIV a=0x8000_0000, b=0xFFFF_FFFF -> 0x8000_0000; REM same operands -> 0.
- Flush during CALC (E0+10) -> IDLE at E0+11, `gnt_o`=1, `busy_o`=0, no `rvalid_o` ever. Next DIVU 9/3 accepted -> 3.
- Back-to-back: `req_i` held high with two DIVU operations -> second accepted the cycle after the first `rvalid_o`. Exactly two strobes, results in order. Assert async reset mid-CALC -> outputs at reset values immediately.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: EX-stage offload handshake between the execute stage
// (master) and the iterative multiply/divide unit (slave).
//   req_i        EX -> unit   request, accepted when req_i && gnt_o
//   op_i[2:0]    EX -> unit   RV32M funct3
//   operand_a_i  EX -> unit   rs1 value
//   operand_b_i  EX -> unit   rs2 value
//   flush_i      EX -> unit   abort any in-flight operation
//   gnt_o        unit -> EX   unit ready to accept
//   result_o     unit -> EX   result, valid when rvalid_o
//   rvalid_o     unit -> EX   one-cycle result strobe
//   busy_o       unit -> EX   operation in flight, result not yet delivered
interface muldiv_unit_if;
    logic        req_i;
    logic        gnt_o;
    logic [2:0]  op_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        flush_i;
    logic [31:0] result_o;
    logic        rvalid_o;
    logic        busy_o;

    modport master (
        output req_i, op_i, operand_a_i, operand_b_i, flush_i,
        input  gnt_o, result_o, rvalid_o, busy_o
    );

    modport slave (
        input  req_i, op_i, operand_a_i, operand_b_i, flush_i,
        output gnt_o, result_o, rvalid_o, busy_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, responder side of the
// EX offload handshake. Operands are latched on accept; multiply is a
// 32-cycle shift-add on magnitudes, divide a 32-cycle restoring divide on
// magnitudes, followed by a single DONE cycle carrying the rvalid_o strobe.
// Divide-by-zero and signed overflow are resolved at accept and go straight
// to DONE.
// Ports:
//   clk_i    clock, all state on rising edge
//   rst_n_i  asynchronous active-low reset
//   bus      muldiv_unit_if.slave (req/gnt/op/operands/flush/result/rvalid/busy)
// Parameter:
//   ISA_M    1 enables the unit; 0 ties every output to 0
// Build option:
//   MULDIV_FAST_MUL_EN  when defined, multiplies use a single-cycle 33x33
//                       signed multiplier and finish at accept+1.
module muldiv_unit #(
    parameter int unsigned ISA_M = 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    muldiv_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    if (ISA_M != 0) begin : g_muldiv
        state_e      state_q, state_d;
        logic [4:0]  cnt_q, cnt_d;
        logic [2:0]  op_q, op_d;
        logic [63:0] acc_q, acc_d;    // mul: {partial product, multiplier}; div: {remainder, quotient}
        logic [31:0] mb_q, mb_d;      // mul: multiplicand magnitude; div: divisor magnitude
        logic        neg_q, neg_d;    // final result needs two's-complement negation
        logic [31:0] result_q, result_d;
        logic        rvalid_q, rvalid_d;

        logic        is_div, a_signed, b_signed, a_neg, b_neg;
        logic [31:0] mag_a, mag_b;
        logic        b_zero, div_ovf;
        logic [32:0] mul_sum;
        logic [63:0] mul_next;
        logic [32:0] div_shift, div_trial;
        logic [63:0] div_next;
        logic [63:0] prod_fix;
        logic [31:0] div_sel, div_fix, fin_word;
        logic [63:0] fast_prod;
        logic [31:0] fast_word;

        if (FAST_MUL) begin : g_fast
            assign fast_prod = 64'($signed({a_neg, bus.operand_a_i}))
                             * 64'($signed({b_neg, bus.operand_b_i}));
        end else begin : g_slow
            assign fast_prod = '0;
        end

        always_comb begin
            // Accept-time decode, only meaningful in IDLE
            is_div   = bus.op_i[2];
            a_signed = is_div ? ~bus.op_i[0] : (bus.op_i[1:0] != 2'b11);
            b_signed = is_div ? ~bus.op_i[0] : ~bus.op_i[1];
            a_neg    = a_signed & bus.operand_a_i[31];
            b_neg    = b_signed & bus.operand_b_i[31];
            mag_a    = a_neg ? (~bus.operand_a_i + 32'd1) : bus.operand_a_i;
            mag_b    = b_neg ? (~bus.operand_b_i + 32'd1) : bus.operand_b_i;
            b_zero   = (bus.operand_b_i == '0);
            div_ovf  = is_div & ~bus.op_i[0] & (bus.operand_a_i == 32'h8000_0000)
                     & (bus.operand_b_i == '1);
            fast_word = (bus.op_i[1:0] == 2'b00) ? fast_prod[31:0] : fast_prod[63:32];

            // One shift-add step: add multiplicand when multiplier LSB set, shift right
            mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mb_q} : 33'd0);
            mul_next = {mul_sum, acc_q[31:1]};

            // One restoring step: shift next dividend bit into remainder, try subtract
            div_shift = {acc_q[63:32], acc_q[31]};
            div_trial = div_shift - {1'b0, mb_q};
            div_next  = div_trial[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                      : {div_trial[31:0], acc_q[30:0], 1'b1};

            // Sign correction and word select on the final step's value
            prod_fix = neg_q ? (~mul_next + 64'd1) : mul_next;
            div_sel  = op_q[1] ? div_next[63:32] : div_next[31:0];
            div_fix  = neg_q ? (~div_sel + 32'd1) : div_sel;
            fin_word = op_q[2] ? div_fix
                     : ((op_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32]);

            state_d  = state_q;
            cnt_d    = cnt_q;
            op_d     = op_q;
            acc_d    = acc_q;
            mb_d     = mb_q;
            neg_d    = neg_q;
            result_d = result_q;
            rvalid_d = 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (!bus.flush_i && bus.req_i) begin
                        op_d  = bus.op_i;
                        // Remainder follows the dividend; quotient/product follow sign mismatch
                        neg_d = (is_div && bus.op_i[1]) ? a_neg : (a_neg ^ b_neg);
                        if (is_div && b_zero) begin
                            result_d = bus.op_i[1] ? bus.operand_a_i : '1;
                            rvalid_d = 1'b1;
                            state_d  = S_DONE;
                        end else if (div_ovf) begin
                            result_d = bus.op_i[1] ? '0 : 32'h8000_0000;
                            rvalid_d = 1'b1;
                            state_d  = S_DONE;
                        end else if (FAST_MUL && !is_div) begin
                            result_d = fast_word;
                            rvalid_d = 1'b1;
                            state_d  = S_DONE;
                        end else begin
                            mb_d    = is_div ? mag_b : mag_a;
                            acc_d   = {32'd0, is_div ? mag_a : mag_b};
                            cnt_d   = 5'd31;
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (bus.flush_i) begin
                        state_d = S_IDLE;
                    end else begin
                        acc_d = op_q[2] ? div_next : mul_next;
                        cnt_d = cnt_q - 5'd1;
                        if (cnt_q == 5'd0) begin
                            result_d = fin_word;
                            rvalid_d = 1'b1;
                            state_d  = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                state_q  <= S_IDLE;
                cnt_q    <= '0;
                op_q     <= '0;
                acc_q    <= '0;
                mb_q     <= '0;
                neg_q    <= 1'b0;
                result_q <= '0;
                rvalid_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                op_q     <= op_d;
                acc_q    <= acc_d;
                mb_q     <= mb_d;
                neg_q    <= neg_d;
                result_q <= result_d;
                rvalid_q <= rvalid_d;
            end
        end

        assign bus.gnt_o    = (state_q == S_IDLE);
        // The strobe is registered into DONE; a flush arriving in that same
        // cycle must still cancel it, hence the late gate.
        assign bus.rvalid_o = rvalid_q & ~bus.flush_i;
        assign bus.busy_o   = (state_q != S_IDLE) && !rvalid_q;
        assign bus.result_o = result_q;
    end else begin : g_no_muldiv
        assign bus.gnt_o    = 1'b0;
        assign bus.rvalid_o = 1'b0;
        assign bus.busy_o   = 1'b0;
        assign bus.result_o = '0;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Directed cases plus
// randomized operations compared against an arithmetic reference model,
// including latency, busy window, flush, back-to-back and async reset.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst_n;

    muldiv_unit_if bus ();

    muldiv_unit #(.ISA_M(1)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: RV32M semantics computed with plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ia = int'(a);
        ib = int'(b);
        case (op)
            3'b000: begin p = 64'(sa * sb); return p[31:0]; end
            3'b001: begin p = 64'(sa * sb); return p[63:32]; end
            3'b010: begin p = 64'(sa * ub); return p[63:32]; end
            3'b011: begin p = 64'(ua * ub); return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'b101: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int unsigned exp_lat(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        if (op[2]) begin
            if (b == 32'd0) return 1;
            if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 1;
`else
        return 33;
`endif
    endfunction

    // Issue one op from an IDLE sample point; returns at the sample point of
    // the IDLE cycle following DONE.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] exp;
        int unsigned lat, k, busy_cnt;
        bit          got;
        exp      = ref_model(op, a, b);
        lat      = exp_lat(op, a, b);
        k        = 1;
        busy_cnt = 0;
        got      = 1'b0;
        bus.req_i       = 1'b1;
        bus.op_i        = op;
        bus.operand_a_i = a;
        bus.operand_b_i = b;
        @(posedge clk); #1;
        // Inputs outside the accept cycle must be ignored
        bus.req_i       = 1'b0;
        bus.op_i        = 3'($urandom);
        bus.operand_a_i = $urandom;
        bus.operand_b_i = $urandom;
        while (!got && k <= 40) begin
            if (bus.rvalid_o) begin
                got = 1'b1;
                check_eq({tag, " latency"}, 32'(k), 32'(lat));
                check_eq({tag, " result"}, bus.result_o, exp);
                check_eq({tag, " busy@strobe"}, 32'(bus.busy_o), 32'd0);
            end else begin
                if (bus.busy_o) busy_cnt++;
                @(posedge clk); #1;
                k++;
            end
        end
        check_eq({tag, " strobe seen"}, 32'(got), 32'd1);
        check_eq({tag, " busy cycles"}, 32'(busy_cnt), 32'(lat - 1));
        @(posedge clk); #1;
        check_eq({tag, " one-cycle strobe"}, 32'(bus.rvalid_o), 32'd0);
        check_eq({tag, " gnt after"}, 32'(bus.gnt_o), 32'd1);
        check_eq({tag, " result hold"}, bus.result_o, exp);
    endtask

    task automatic count_strobes(input int unsigned cycles, output int unsigned n);
        n = 0;
        for (int unsigned i = 0; i < cycles; i++) begin
            if (bus.rvalid_o) n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int unsigned n;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [31:0] res [2];
        int          sc [2];
        int          c, accept_c, strobes;
        bit          acc_now;

        rst_n           = 1'b0;
        bus.req_i       = 1'b0;
        bus.flush_i     = 1'b0;
        bus.op_i        = '0;
        bus.operand_a_i = '0;
        bus.operand_b_i = '0;
        #12;
        check_eq("reset gnt", 32'(bus.gnt_o), 32'd1);
        check_eq("reset busy", 32'(bus.busy_o), 32'd0);
        check_eq("reset rvalid", 32'(bus.rvalid_o), 32'd0);
        check_eq("reset result", bus.result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op("MUL 7*-3",      3'b000, 32'd7,           32'hFFFF_FFFD);
        run_op("MULH min*min",  3'b001, 32'h8000_0000,   32'h8000_0000);
        run_op("MULHU",         3'b011, 32'h8000_0000,   32'h8000_0000);
        run_op("MULHSU -1*max", 3'b010, 32'hFFFF_FFFF,   32'hFFFF_FFFF);
        run_op("DIV -7/2",      3'b100, 32'hFFFF_FFF9,   32'd2);
        run_op("REM -7%2",      3'b110, 32'hFFFF_FFF9,   32'd2);
        run_op("DIVU 100/7",    3'b101, 32'd100,         32'd7);
        run_op("REMU 100%7",    3'b111, 32'd100,         32'd7);
        run_op("DIVU /0",       3'b101, 32'h0000_1234,   32'd0);
        run_op("REM /0",        3'b110, 32'h0000_1234,   32'd0);
        run_op("DIV ovf",       3'b100, 32'h8000_0000,   32'hFFFF_FFFF);
        run_op("REM ovf",       3'b110, 32'h8000_0000,   32'hFFFF_FFFF);

        // Flush during CALC
        bus.req_i = 1'b1; bus.op_i = 3'b101; bus.operand_a_i = 32'd1000; bus.operand_b_i = 32'd7;
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        check_eq("flush gnt", 32'(bus.gnt_o), 32'd1);
        check_eq("flush busy", 32'(bus.busy_o), 32'd0);
        count_strobes(40, n);
        check_eq("flush no strobe", 32'(n), 32'd0);
        run_op("DIVU 9/3 after flush", 3'b101, 32'd9, 32'd3);

        // Flush together with request in IDLE: nothing accepted
        bus.req_i = 1'b1; bus.flush_i = 1'b1;
        bus.op_i = 3'b000; bus.operand_a_i = 32'd5; bus.operand_b_i = 32'd6;
        @(posedge clk); #1;
        bus.req_i = 1'b0; bus.flush_i = 1'b0;
        check_eq("flush+req gnt", 32'(bus.gnt_o), 32'd1);
        check_eq("flush+req busy", 32'(bus.busy_o), 32'd0);
        count_strobes(40, n);
        check_eq("flush+req no strobe", 32'(n), 32'd0);

        // Back-to-back with req held high
        strobes  = 0;
        accept_c = -1;
        sc[0] = -100; sc[1] = -100;
        res[0] = '0; res[1] = '0;
        bus.req_i = 1'b1; bus.op_i = 3'b101; bus.operand_a_i = 32'd1000; bus.operand_b_i = 32'd10;
        @(posedge clk); #1;
        bus.operand_a_i = 32'd77; bus.operand_b_i = 32'd5;
        c = 1;
        while (c <= 100 && strobes < 2) begin
            if (bus.rvalid_o) begin
                res[strobes] = bus.result_o;
                sc[strobes]  = c;
                strobes++;
            end
            acc_now = bus.gnt_o && bus.req_i;
            if (acc_now) accept_c = c;
            @(posedge clk); #1;
            if (acc_now) bus.req_i = 1'b0;
            c++;
        end
        bus.req_i = 1'b0;
        count_strobes(40, n);
        check_eq("b2b strobes", 32'(strobes + int'(n)), 32'd2);
        check_eq("b2b accept slot", 32'(accept_c), 32'(sc[0] + 1));
        check_eq("b2b res0", res[0], 32'd100);
        check_eq("b2b res1", res[1], 32'd15);

        // Async reset mid-CALC; last delivered result is non-zero
        run_op("DIVU 9/3 pre-reset", 3'b101, 32'd9, 32'd3);
        bus.req_i = 1'b1; bus.op_i = 3'b101; bus.operand_a_i = 32'd500; bus.operand_b_i = 32'd3;
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst gnt", 32'(bus.gnt_o), 32'd1);
        check_eq("rst busy", 32'(bus.busy_o), 32'd0);
        check_eq("rst rvalid", 32'(bus.rvalid_o), 32'd0);
        check_eq("rst result", bus.result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        count_strobes(40, n);
        check_eq("rst no strobe", 32'(n), 32'd0);

        // Randomized operations with biased corner operands
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 20)); b = 32'($urandom_range(1, 5)); end
                3: a = 32'h8000_0000;
                4: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op($sformatf("rnd%0d op%0d", i, op), op, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
